// File: rtl/timer_pkg.sv
//------------------------------------------------------------------------------
// Module  : timer_pkg
// Purpose : Shared definitions for the memory-mapped timer: register offsets,
//           CTRL/STATUS bit positions and the timer state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package timer_pkg;

    // Word offsets within the 16-byte window (dataadr[3:2])
    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_COUNT   = 2'd1;
    localparam logic [1:0] OFF_COMPARE = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_PRE_LSB = 8;

    // STATUS bit positions
    localparam int STATUS_MATCH  = 0;
    localparam int STATUS_WRAP   = 1;
    localparam int STATUS_ST_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tstate_t;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
//------------------------------------------------------------------------------
// Module  : timer_prescaler
// Purpose : Clock divider for the timer. Counts 0..prescale while enabled and
//           emits a one-cycle tick on the cycle the count equals prescale.
// Ports   : clk, reset (async, active-high), clr (synchronous clear),
//           en (count enable), prescale (terminal value), tick (pulse out)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    assign tick = en && (pre_q == prescale);

    // clr has priority so a fresh start always begins a full period
    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_timer.sv
//------------------------------------------------------------------------------
// Module  : mmio_timer
// Purpose : Memory-mapped timer/counter on the data bus. Prescaled 32-bit
//           up-counter with compare match, one-shot / auto-reload modes and a
//           registered level interrupt.
// Ports   : clk, reset (async, active-high)
//           memwrite, dataadr[31:0], writedata[31:0]  - bus request from core
//           readdata[31:0] - selected register (0 when not hit)
//           hit            - address falls in this block's window
//           irq            - STATUS.MATCH & CTRL.IRQ_EN, registered
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mmio_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h0000_0080,
    parameter int          PRE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        hit,
    output logic        irq
);

    tstate_t           state_q, state_d;
    logic              en_q, en_d;
    logic              auto_q, auto_d;
    logic              irq_en_q, irq_en_d;
    logic [PRE_W-1:0]  prescale_q, prescale_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       compare_q, compare_d;
    logic              match_q, match_d;
    logic              wrap_q, wrap_d;
    logic              irq_q, irq_d;

    logic [1:0]        w_off;
    logic              w_wr;
    logic              w_clr;
    logic              w_tick;
    logic              w_set_match;
    logic              w_set_wrap;
    logic              w_unused_adr;

    assign hit          = (dataadr[31:4] == BASE[31:4]);
    assign w_off        = dataadr[3:2];
    assign w_wr         = memwrite && hit;
    assign w_unused_adr = ^dataadr[1:0];

    // Prescaler restarts only when entering RUN; an EN=1 write while already
    // running leaves the current period untouched.
    assign w_clr = w_wr && (w_off == OFF_CTRL) && writedata[CTRL_EN]
                   && (state_q != ST_RUN);

    timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_clr),
        .en       (state_q == ST_RUN),
        .prescale (prescale_q),
        .tick     (w_tick)
    );

    // Next-state: tick effects first, then software writes override the
    // fields they touch (COUNT write beats increment, CTRL write decides state).
    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        auto_d      = auto_q;
        irq_en_d    = irq_en_q;
        prescale_d  = prescale_q;
        count_d     = count_q;
        compare_d   = compare_q;
        w_set_match = 1'b0;
        w_set_wrap  = 1'b0;

        if (w_tick) begin
            if (count_q == compare_q) begin
                w_set_match = 1'b1;
                if (auto_q) begin
                    count_d = '0;
                end else begin
                    state_d = ST_DONE;
                    en_d    = 1'b0;
                end
            end else begin
                count_d    = count_q + 32'd1;
                w_set_wrap = (count_q == 32'hFFFF_FFFF);
            end
        end

        // Sticky flags: W1C is applied before the OR so a same-edge set wins
        match_d = match_q;
        wrap_d  = wrap_q;
        if (w_wr && (w_off == OFF_STATUS)) begin
            match_d = match_q & ~writedata[STATUS_MATCH];
            wrap_d  = wrap_q  & ~writedata[STATUS_WRAP];
        end
        match_d = match_d | w_set_match;
        wrap_d  = wrap_d  | w_set_wrap;

        if (w_wr && (w_off == OFF_COUNT)) begin
            count_d = writedata;
        end
        if (w_wr && (w_off == OFF_COMPARE)) begin
            compare_d = writedata;
        end
        if (w_wr && (w_off == OFF_CTRL)) begin
            en_d       = writedata[CTRL_EN];
            auto_d     = writedata[CTRL_AUTO];
            irq_en_d   = writedata[CTRL_IRQ_EN];
            prescale_d = writedata[CTRL_PRE_LSB +: PRE_W];
            state_d    = writedata[CTRL_EN] ? ST_RUN : ST_IDLE;
        end

        irq_d = match_q & irq_en_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            match_q    <= 1'b0;
            wrap_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            wrap_q     <= wrap_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

    always_comb begin
        readdata = '0;
        if (hit) begin
            case (w_off)
                OFF_CTRL: begin
                    readdata[CTRL_EN]                   = en_q;
                    readdata[CTRL_AUTO]                 = auto_q;
                    readdata[CTRL_IRQ_EN]               = irq_en_q;
                    readdata[CTRL_PRE_LSB +: PRE_W]     = prescale_q;
                end
                OFF_COUNT:   readdata = count_q;
                OFF_COMPARE: readdata = compare_q;
                default: begin
                    readdata[STATUS_MATCH]              = match_q;
                    readdata[STATUS_WRAP]               = wrap_q;
                    readdata[STATUS_ST_LSB +: 2]        = state_q;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer.sv
//------------------------------------------------------------------------------
// Module  : tb_mmio_timer
// Purpose : Self-checking bench for mmio_timer: directed scenarios with
//           literal expectations plus randomized bus traffic, all compared
//           against a behavioural model of the peripheral.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        hit;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_timer #(
        .BASE  (BASE),
        .PRE_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .hit       (hit),
        .irq       (irq)
    );

    // ---------------- behavioural model ----------------
    // Timer described as plain values: mode flags, a divider counter that
    // fires every (ps+1) running cycles, the count, and sticky flags.
    // Phase: 0 idle, 1 running, 2 finished.
    typedef struct packed {
        logic        en;
        logic        auto_rl;
        logic        irqen;
        logic [7:0]  ps;
        logic [7:0]  div;
        logic [31:0] count;
        logic [31:0] compare;
        logic        match;
        logic        wrap;
        logic [1:0]  phase;
        logic        irq;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t cur, input logic we,
                                          input logic [31:0] adr, input logic [31:0] wd);
        model_t nx;
        logic   in_win;
        int     reg_idx;
        logic   fire;
        nx      = cur;
        in_win  = (adr >= BASE) && (adr < BASE + 32'd16);
        reg_idx = int'((adr - BASE) >> 2);
        fire    = (cur.phase == 2'd1) && (cur.div == cur.ps);

        nx.irq = cur.match && cur.irqen;

        if (cur.phase == 2'd1) nx.div = fire ? 8'd0 : cur.div + 8'd1;

        if (fire) begin
            if (cur.count == cur.compare) begin
                if (cur.auto_rl) nx.count = 0;
                else begin
                    nx.phase = 2'd2;
                    nx.en    = 1'b0;
                end
            end else begin
                nx.count = cur.count + 1;
            end
        end

        if (we && in_win && reg_idx == 3) begin
            if (wd[0]) nx.match = 1'b0;
            if (wd[1]) nx.wrap  = 1'b0;
        end
        if (fire && cur.count == cur.compare) nx.match = 1'b1;
        if (fire && cur.count != cur.compare && cur.count == 32'hFFFF_FFFF) nx.wrap = 1'b1;

        if (we && in_win) begin
            case (reg_idx)
                0: begin
                    nx.en      = wd[0];
                    nx.auto_rl = wd[1];
                    nx.irqen   = wd[2];
                    nx.ps      = wd[15:8];
                    if (wd[0] && cur.phase != 2'd1) nx.div = 8'd0;
                    nx.phase   = wd[0] ? 2'd1 : 2'd0;
                end
                1: nx.count   = wd;
                2: nx.compare = wd;
                default: ;
            endcase
        end
        return nx;
    endfunction

    function automatic logic [31:0] model_read(input model_t cur, input logic [31:0] adr);
        logic [31:0] r;
        r = 32'h0;
        if (adr >= BASE && adr < BASE + 32'd16) begin
            case (int'((adr - BASE) >> 2))
                0: r = {16'h0, cur.ps, 5'h0, cur.irqen, cur.auto_rl, cur.en};
                1: r = cur.count;
                2: r = cur.compare;
                default: r = {28'h0, cur.phase, cur.wrap, cur.match};
            endcase
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= model_step(m, memwrite, dataadr, writedata);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle out of reset, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            check("model_hit", {31'h0, hit},
                  {31'h0, (dataadr >= BASE && dataadr < BASE + 32'd16)});
            check("model_readdata", readdata, model_read(m, dataadr));
            check("model_irq", {31'h0, irq}, {31'h0, m.irq});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        memwrite  = we;
        dataadr   = adr;
        writedata = wd;
    endtask

    task automatic rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
        bus(1'b0, adr, 32'h0);
        #1;
        check(name, readdata, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, BASE + 32'h20, 32'h0);
    endtask

    // Asynchronous reset pulse starting mid-cycle
    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        memwrite = 1'b0;
        dataadr  = BASE + 32'h4;
        #0.5;
        check("rst_count_zero", readdata, 32'h0);
        check("rst_irq_zero", {31'h0, irq}, 32'h0);
        check("rst_hit_in", {31'h0, hit}, 32'h1);
        dataadr = BASE + 32'h20;
        #0.5;
        check("rst_hit_out", {31'h0, hit}, 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] adr;
        logic [31:0] wd;
        logic        we;
        int          off;

        #12;
        reset = 1'b0;

        // Reset state
        rd("reset_ctrl",    BASE + 32'h0, 32'h0);
        rd("reset_count",   BASE + 32'h4, 32'h0);
        rd("reset_compare", BASE + 32'h8, 32'h0);
        rd("reset_status",  BASE + 32'hC, 32'h0);

        // One-shot: COMPARE=3, EN, PRESCALE=0
        bus(1'b1, BASE + 32'h8, 32'd3);
        bus(1'b1, BASE + 32'h0, 32'h0000_0001);
        idle(4);
        rd("oneshot_status", BASE + 32'hC, 32'h9);
        rd("oneshot_count",  BASE + 32'h4, 32'd3);
        rd("oneshot_ctrl",   BASE + 32'h0, 32'h0);

        // Auto-reload with PRESCALE=2 and W1C collision
        async_reset();
        bus(1'b1, BASE + 32'h8, 32'd2);
        bus(1'b1, BASE + 32'h0, 32'h0000_0207);
        idle(3);
        rd("auto_count_e3", BASE + 32'h4, 32'd1);
        idle(5);
        rd("auto_first_match", BASE + 32'hC, 32'h5);
        rd("auto_count_reload", BASE + 32'h4, 32'd0);
        check("auto_irq_high", {31'h0, irq}, 32'h1);
        idle(6);
        bus(1'b1, BASE + 32'hC, 32'h1);       // lands on the 2nd match edge
        rd("w1c_collision", BASE + 32'hC, 32'h5);
        bus(1'b1, BASE + 32'hC, 32'h1);
        rd("w1c_clear", BASE + 32'hC, 32'h4);
        check("irq_still_high", {31'h0, irq}, 32'h1);
        idle(1);
        #1;
        check("irq_dropped", {31'h0, irq}, 32'h0);

        // Wrap
        async_reset();
        bus(1'b1, BASE + 32'h4, 32'hFFFF_FFFE);
        bus(1'b1, BASE + 32'h8, 32'd5);
        bus(1'b1, BASE + 32'h0, 32'h1);
        idle(2);
        rd("wrap_count",  BASE + 32'h4, 32'h0);
        rd("wrap_status", BASE + 32'hC, 32'h6);

        // Decode: writes just outside the window
        async_reset();
        bus(1'b1, BASE + 32'h10, 32'hDEAD_BEEF);
        bus(1'b1, BASE - 32'h4,  32'hDEAD_BEEF);
        rd("decode_above", BASE + 32'h10, 32'h0);
        check("decode_hit0", {31'h0, hit}, 32'h0);
        rd("decode_ctrl",    BASE + 32'h0, 32'h0);
        rd("decode_count",   BASE + 32'h4, 32'h0);
        rd("decode_compare", BASE + 32'h8, 32'h0);
        rd("decode_status",  BASE + 32'hC, 32'h0);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) async_reset();
            off = $urandom_range(0, 3);
            adr = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                adr = ($urandom_range(0, 1) == 1) ? BASE + 32'h10 + 32'($urandom_range(0, 15))
                                                  : BASE - 32'($urandom_range(1, 16));
            we = ($urandom_range(0, 99) < 15);
            wd = $urandom;
            case (off)
                0: begin
                    wd[15:8] = 8'($urandom_range(0, 3));
                    wd[0]    = ($urandom_range(0, 3) != 0);
                end
                1: wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 8))
                                                    : 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                2: wd = 32'($urandom_range(0, 8));
                default: ;
            endcase
            bus(we, adr, wd);
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
